// File: rtl/multi_dataflow_sobel_mdc_tcdm_pkg.sv
// multi_dataflow_sobel_mdc_tcdm_pkg: shared defaults, decode and response types for the TCDM responder
package multi_dataflow_sobel_mdc_tcdm_pkg;
   localparam int          NP_DEF         = 3;
   localparam int          NB_DEF         = 4;
   localparam int          BANK_WORDS_DEF = 1024;
   localparam logic [31:0] BASE_ADDR_DEF  = 32'h1000_0000;
   localparam logic [31:0] OOR_RDATA      = 32'hDEAD_BEEF;

   typedef struct packed {
      logic [31:0] bank;
      logic [31:0] row;
      logic        oor;
   } tcdm_dec_t;

   typedef struct packed {
      logic [31:0] r_data;
      logic        r_valid;
   } tcdm_resp_t;

   // word-interleaved decode: low word bits pick the bank, the rest the row
   function automatic tcdm_dec_t tcdm_decode(input logic [31:0] add, input logic [31:0] base,
                                             input int nb_log, input logic [31:0] words);
      logic [31:0] word;
      tcdm_dec_t   d;
      word   = (add - base) >> 2;
      d.bank = word & ((32'd1 << nb_log) - 32'd1);
      d.row  = word >> nb_log;
      d.oor  = word >= words;
      return d;
   endfunction
endpackage

// File: rtl/multi_dataflow_sobel_mdc_rr_arb.sv
// multi_dataflow_sobel_mdc_rr_arb: per-bank round-robin arbiter with its own pointer
module multi_dataflow_sobel_mdc_rr_arb #(
   parameter int NP = 3
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic [NP-1:0] cand_i,
   output logic [NP-1:0] gnt_o
);
   localparam int PW = NP > 1 ? $clog2(NP) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic          found;

   // first candidate at or after the pointer, wrapping
   always_comb begin
      int idx;
      idx   = 0;
      gnt_o = '0;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < NP; i++) begin
         idx = (int'(ptr) + i) % NP;
         if (!found && cand_i[idx]) begin
            gnt_o[idx] = 1'b1;
            win        = PW'(idx);
            found      = 1'b1;
         end
      end
   end

   // pointer moves past the winner; idle cycles leave it alone
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ptr <= '0;
      else if (clear_i) ptr <= '0;
      else if (found) ptr <= (int'(win) == NP - 1) ? '0 : win + 1'b1;
   end
endmodule

// File: rtl/multi_dataflow_sobel_mdc_tcdm_responder.sv
// multi_dataflow_sobel_mdc_tcdm_responder: banked TCDM slave model with conflict and range monitoring
module multi_dataflow_sobel_mdc_tcdm_responder
   import multi_dataflow_sobel_mdc_tcdm_pkg::*;
#(
   parameter int          NP         = NP_DEF,
   parameter int          NB         = NB_DEF,
   parameter int          BANK_WORDS = BANK_WORDS_DEF,
   parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [NP-1:0]    req_i,
   output logic [NP-1:0]    gnt_o,
   input  logic [NP*32-1:0] add_i,
   input  logic [NP-1:0]    wen_i,
   input  logic [NP*4-1:0]  be_i,
   input  logic [NP*32-1:0] data_i,
   output logic [NP*32-1:0] r_data_o,
   output logic [NP-1:0]    r_valid_o,
   input  logic [NP-1:0]    stall_i,
   output logic [15:0]      conflicts_o,
   output logic             oor_err_o,
   input  logic             clear_i
);
   localparam int          BW    = $clog2(NB);
   localparam int          RW    = $clog2(BANK_WORDS);
   localparam logic [31:0] WORDS = 32'(NB * BANK_WORDS);

   tcdm_dec_t   dec [NP];
   tcdm_resp_t  resp [NP];
   logic [NP-1:0] cand [NB];
   logic [NP-1:0] arb_gnt [NB];
   logic [NP-1:0] gnt;
   logic [NP-1:0] oor_vec;
   logic [31:0]   conf_inc;
   logic [31:0]   conf_sum;
   logic [31:0]   mem [NB][BANK_WORDS];

   // decode every port and build per-bank candidate sets; nothing competes during reset
   always_comb begin
      for (int p = 0; p < NP; p++) begin
         dec[p]     = tcdm_decode(add_i[p*32+:32], BASE_ADDR, BW, WORDS);
         oor_vec[p] = dec[p].oor;
      end
      for (int b = 0; b < NB; b++) begin
         cand[b] = '0;
         for (int p = 0; p < NP; p++)
            cand[b][p] = req_i[p] & ~stall_i[p] & ~rst_i & (dec[p].bank == 32'(b));
      end
   end

   for (genvar b = 0; b < NB; b++) begin : g_arb
      multi_dataflow_sobel_mdc_rr_arb #(.NP(NP)) u_arb (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .clear_i(clear_i),
         .cand_i (cand[b]),
         .gnt_o  (arb_gnt[b])
      );
   end

   // merge bank grants and count losers across all banks
   always_comb begin
      gnt      = '0;
      conf_inc = '0;
      for (int b = 0; b < NB; b++) begin
         gnt = gnt | arb_gnt[b];
         if (cand[b] != '0) conf_inc = conf_inc + 32'($countones(cand[b]) - 1);
      end
      conf_sum = {16'h0, conflicts_o} + conf_inc;
   end

   // SRAM write port: byte-masked, in-range granted writes only; contents survive reset
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < NP; p++)
         if (gnt[p] && !wen_i[p] && !dec[p].oor)
            for (int k = 0; k < 4; k++)
               if (be_i[p*4+k])
                  mem[dec[p].bank[BW-1:0]][dec[p].row[RW-1:0]][8*k+:8] <= data_i[p*32+8*k+:8];
   end

   // one-cycle read response; data holds between responses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int p = 0; p < NP; p++) resp[p] <= '0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            resp[p].r_valid <= gnt[p] & wen_i[p];
            if (gnt[p] && wen_i[p])
               resp[p].r_data <= dec[p].oor ? OOR_RDATA : mem[dec[p].bank[BW-1:0]][dec[p].row[RW-1:0]];
         end
      end
   end

   // saturating conflict counter and sticky out-of-range flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         conflicts_o <= '0;
         oor_err_o   <= 1'b0;
      end else if (clear_i) begin
         conflicts_o <= '0;
         oor_err_o   <= 1'b0;
      end else begin
         conflicts_o <= (conf_sum[31:16] != '0) ? 16'hFFFF : conf_sum[15:0];
         oor_err_o   <= oor_err_o | (|(gnt & oor_vec));
      end
   end

   // flatten responses onto the port buses
   always_comb begin
      gnt_o = gnt;
      for (int p = 0; p < NP; p++) begin
         r_data_o[p*32+:32] = resp[p].r_data;
         r_valid_o[p]       = resp[p].r_valid;
      end
   end
endmodule

// File: tb/tb_multi_dataflow_sobel_mdc_tcdm_responder.sv
// tb_multi_dataflow_sobel_mdc_tcdm_responder: directed scoreboard bench for the TCDM responder
module tb_multi_dataflow_sobel_mdc_tcdm_responder;
   localparam int          NP    = 3;
   localparam int          NB    = 4;
   localparam int          BWDS  = 1024;
   localparam logic [31:0] BASE  = 32'h1000_0000;
   localparam logic [31:0] TOTAL = 32'(NB * BWDS);
   localparam logic [31:0] OOR   = 32'hDEAD_BEEF;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic [NP-1:0]    req_s = '0;
   logic [NP-1:0]    gnt_o;
   logic [NP*32-1:0] add_s = '0;
   logic [NP-1:0]    wen_s = '0;
   logic [NP*4-1:0]  be_s = '0;
   logic [NP*32-1:0] data_s = '0;
   logic [NP*32-1:0] r_data_o;
   logic [NP-1:0]    r_valid_o;
   logic [NP-1:0]    stall_s = '0;
   logic [15:0]      conflicts_o;
   logic             oor_err_o;
   logic             clear_s = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] model [logic [31:0]];
   logic [31:0] q [NP][$];

   always #5 clk_i = ~clk_i;

   multi_dataflow_sobel_mdc_tcdm_responder #(
      .NP(NP), .NB(NB), .BANK_WORDS(BWDS), .BASE_ADDR(BASE)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_s), .gnt_o(gnt_o), .add_i(add_s),
      .wen_i(wen_s), .be_i(be_s), .data_i(data_s), .r_data_o(r_data_o),
      .r_valid_o(r_valid_o), .stall_i(stall_s), .conflicts_o(conflicts_o),
      .oor_err_o(oor_err_o), .clear_i(clear_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int p, input logic r, input logic we, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d);
      req_s[p]          = r;
      wen_s[p]          = we;
      add_s[p*32+:32]   = a;
      be_s[p*4+:4]      = b;
      data_s[p*32+:32]  = d;
   endtask

   // check grants, update the model / push expected reads, clock, then check responses
   task automatic tick(input logic [NP-1:0] eg, input string tag);
      logic [NP-1:0] due;
      logic [31:0]   w;
      logic [31:0]   old;
      logic [31:0]   d;
      #1;
      chk({tag, "_gnt"}, 32'(gnt_o), 32'(eg));
      due = '0;
      for (int p = 0; p < NP; p++) begin
         if (eg[p]) begin
            w = (add_s[p*32+:32] - BASE) >> 2;
            if (wen_s[p]) begin
               due[p] = 1'b1;
               q[p].push_back(w >= TOTAL ? OOR : model[w]);
            end else if (w < TOTAL) begin
               old = model.exists(w) ? model[w] : 32'h0;
               for (int k = 0; k < 4; k++)
                  if (be_s[p*4+k]) old[8*k+:8] = data_s[p*32+8*k+:8];
               model[w] = old;
            end
         end
      end
      @(posedge clk_i);
      #1;
      for (int p = 0; p < NP; p++) begin
         chk({tag, "_rvalid"}, 32'(r_valid_o[p]), 32'(due[p]));
         if (due[p]) begin
            d = q[p].pop_front();
            chk({tag, "_rdata"}, r_data_o[p*32+:32], d);
         end
      end
   endtask

   initial begin
      // reset state, with requests present to show grants are suppressed
      req_s = '1;
      wen_s = '1;
      #2;
      chk("rst_gnt", 32'(gnt_o), 32'h0);
      chk("rst_rvalid", 32'(r_valid_o), 32'h0);
      chk("rst_rdata", r_data_o[31:0], 32'h0);
      chk("rst_conf", 32'(conflicts_o), 32'h0);
      chk("rst_oor", 32'(oor_err_o), 32'h0);
      @(posedge clk_i);
      #1;
      req_s = '0;
      rst_i = 1'b0;

      // write then read back next cycle
      set_port(0, 1, 0, BASE + 32'h10, 4'hF, 32'hCAFE_F00D);
      tick(3'b001, "wr10");
      set_port(0, 1, 1, BASE + 32'h10, 4'h0, 32'h0);
      tick(3'b001, "rd10");
      chk("rd10_val", r_data_o[31:0], 32'hCAFE_F00D);
      set_port(0, 0, 1, BASE, 4'h0, 32'h0);
      tick(3'b000, "hold");
      chk("hold_rdata", r_data_o[31:0], 32'hCAFE_F00D);

      // byte-enable merge
      set_port(0, 1, 0, BASE + 32'h20, 4'hF, 32'hFFFF_FFFF);
      tick(3'b001, "wr20");
      set_port(0, 1, 0, BASE + 32'h20, 4'b0101, 32'h1122_3344);
      tick(3'b001, "wr20be");
      set_port(0, 1, 1, BASE + 32'h20, 4'h0, 32'h0);
      tick(3'b001, "rd20");
      chk("rd20_val", r_data_o[31:0], 32'hFF22_FF44);

      // parallel writes into banks 0 and 1
      set_port(0, 0, 1, BASE, 4'h0, 32'h0);
      set_port(1, 1, 0, BASE + 32'h00, 4'hF, 32'hA5A5_A5A5);
      set_port(2, 1, 0, BASE + 32'h14, 4'hF, 32'h5555_AAAA);
      tick(3'b110, "wrpar");
      req_s = '0;
      chk("wrpar_conf", 32'(conflicts_o), 32'h0);

      // three-way conflict on bank 0, requests dropped once granted
      clear_s = 1'b1;
      tick(3'b000, "clr1");
      clear_s = 1'b0;
      set_port(0, 1, 1, BASE + 32'h10, 4'h0, 32'h0);
      set_port(1, 1, 1, BASE + 32'h00, 4'h0, 32'h0);
      set_port(2, 1, 1, BASE + 32'h20, 4'h0, 32'h0);
      tick(3'b001, "rr0");
      req_s[0] = 1'b0;
      tick(3'b010, "rr1");
      req_s[1] = 1'b0;
      tick(3'b100, "rr2");
      req_s[2] = 1'b0;
      chk("rr_conf", 32'(conflicts_o), 32'd3);

      // distinct banks granted together, no conflict
      set_port(0, 1, 1, BASE + 32'h10, 4'h0, 32'h0);
      set_port(1, 1, 1, BASE + 32'h14, 4'h0, 32'h0);
      tick(3'b011, "par");
      req_s = '0;
      chk("par_conf", 32'(conflicts_o), 32'd3);

      // out-of-range read
      set_port(0, 1, 1, BASE + TOTAL * 4, 4'h0, 32'h0);
      tick(3'b001, "oor");
      chk("oor_flag", 32'(oor_err_o), 32'h1);
      req_s = '0;
      tick(3'b000, "oor_idle");
      chk("oor_sticky", 32'(oor_err_o), 32'h1);
      clear_s = 1'b1;
      tick(3'b000, "clr2");
      clear_s = 1'b0;
      chk("clr_oor", 32'(oor_err_o), 32'h0);
      chk("clr_conf", 32'(conflicts_o), 32'h0);

      // stall hides port 1 from arbitration and conflict counting
      set_port(0, 1, 1, BASE + 32'h00, 4'h0, 32'h0);
      set_port(1, 1, 1, BASE + 32'h10, 4'h0, 32'h0);
      stall_s[1] = 1'b1;
      tick(3'b001, "stall0");
      req_s[0] = 1'b0;
      chk("stall_conf", 32'(conflicts_o), 32'h0);
      tick(3'b000, "stall1");
      stall_s[1] = 1'b0;
      tick(3'b010, "unstall");
      req_s = '0;

      // reset in the response cycle kills r_valid at once
      set_port(0, 1, 1, BASE + 32'h10, 4'h0, 32'h0);
      #1;
      chk("mid_gnt", 32'(gnt_o), 32'h1);
      @(posedge clk_i);
      #1;
      chk("mid_rvalid", 32'(r_valid_o), 32'h1);
      rst_i = 1'b1;
      #1;
      chk("mid_rst_rvalid", 32'(r_valid_o), 32'h0);
      chk("mid_rst_rdata", r_data_o[31:0], 32'h0);
      chk("mid_rst_gnt", 32'(gnt_o), 32'h0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // reset before the edge drops the pending response
      #1;
      chk("drop_gnt", 32'(gnt_o), 32'h1);
      #2;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("drop_rvalid", 32'(r_valid_o), 32'h0);
      rst_i = 1'b0;

      // memory survives reset
      tick(3'b001, "post_rd10");
      set_port(0, 0, 1, BASE, 4'h0, 32'h0);
      set_port(2, 1, 1, BASE + 32'h20, 4'h0, 32'h0);
      tick(3'b100, "post_rd20");
      req_s = '0;

      // held requests rotate and the counter saturates
      set_port(0, 1, 1, BASE + 32'h10, 4'h0, 32'h0);
      set_port(1, 1, 1, BASE + 32'h00, 4'h0, 32'h0);
      set_port(2, 1, 1, BASE + 32'h20, 4'h0, 32'h0);
      for (int i = 0; i < 32767; i++) tick(3'(1 << (i % 3)), "sat");
      chk("sat_pre", 32'(conflicts_o), 32'd65534);
      tick(3'b010, "sat_a");
      chk("sat_max", 32'(conflicts_o), 32'hFFFF);
      tick(3'b100, "sat_b");
      chk("sat_hold", 32'(conflicts_o), 32'hFFFF);
      req_s = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
